// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO read-side blocks: index/level widths and
// the width of the optional statistics counters.
package fifo_pkg;

  localparam int STAT_WIDTH = 32;

  // Index width for a circular buffer of the given depth (at least 1 bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width needed to hold an occupancy count from 0 to depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying FIFO words to the downstream consumer.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Circular output buffer for fifo_rd_stream: push at tail, pop at head,
// synchronous flush. The head entry is presented combinationally.
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2,
  localparam int PW = ptr_width(BUF_DEPTH),
  localparam int LW = level_width(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [LW-1:0]         count,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    return (idx == PW'(BUF_DEPTH - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Storage, indices and occupancy; flush empties the buffer and drops any push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= next_idx(tail);
      end
      if (pop) head <= next_idx(head);
      count <= count + LW'(push) - LW'(pop);
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side engine: drains a FIFO read port (1-cycle read latency) into a
// small prefetch buffer and presents the words as a valid/ready stream.
// Optional statistics counters are built when FIFO_RD_STREAM_STATS_EN is defined.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                          rd_clk,
  input  logic                          rd_rst,
  input  logic                          fifo_empty,
  output logic                          fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]         fifo_rd_data,
  input  logic                          flush,
  fifo_rd_stream_if.master              m_if,
  output logic [$clog2(BUF_DEPTH):0]    buf_level
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]         stat_words,
  output logic [STAT_WIDTH-1:0]         stat_stalls
`endif
);

  localparam int LW = level_width(BUF_DEPTH);

  logic          inflight;
  logic          flush_pend;
  logic          pop;
  logic          push;
  logic [LW-1:0] count;

  assign pop        = m_if.valid && m_if.ready;
  assign m_if.valid = (count != '0);
  assign buf_level  = count;

  // A returning word is dropped if a flush is active now or happened the cycle before.
  assign push = inflight && !flush && !flush_pend;

  // Issue a read only when the word is guaranteed a free slot on arrival.
  always_comb begin
    fifo_rd_en = !fifo_empty && !flush && !rd_rst &&
                 ((int'(count) + int'(inflight) - int'(pop)) < BUF_DEPTH);
  end

  // Track the read in flight and remember a flush for one cycle.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      inflight   <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      inflight   <= fifo_rd_en;
      flush_pend <= flush;
    end
  end

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .flush     (flush),
    .push      (push),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .count     (count),
    .head_data (m_if.data)
  );

`ifdef FIFO_RD_STREAM_STATS_EN
  // Transfer and stall counters; they survive flush and wrap naturally.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      stat_words  <= '0;
      stat_stalls <= '0;
    end else begin
      if (pop) stat_words <= stat_words + 1'b1;
      if (m_if.valid && !m_if.ready) stat_stalls <= stat_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: a FIFO model feeds the DUT and a
// scoreboard checks delivered words against FIFO order (minus flushed words).
module tb_fifo_rd_stream;

  localparam int DW   = 8;
  localparam int BD   = 2;
  localparam int FD   = 4096;

  logic          rd_clk;
  logic          rd_rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          flush;
  logic [$clog2(BD):0] buf_level;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0]   stat_words;
  logic [31:0]   stat_stalls;
`endif

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) m_if ();

  fifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(BD)) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .flush        (flush),
    .m_if         (m_if),
    .buf_level    (buf_level)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .stat_words   (stat_words),
    .stat_stalls  (stat_stalls)
`endif
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // FIFO model: words stored by index, wr_ptr advanced by stimulus, rd_ptr by reads.
  logic [DW-1:0] fifo_mem [FD];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          force_empty;

  assign fifo_empty = (wr_ptr == rd_ptr) || force_empty;

  always @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_ptr       <= wr_ptr;
      fifo_rd_data <= '0;
    end else if (fifo_rd_en) begin
      if (wr_ptr != rd_ptr) begin
        fifo_rd_data <= fifo_mem[rd_ptr % FD];
        rd_ptr       <= rd_ptr + 1;
      end else begin
        fifo_rd_data <= 8'hEE;
      end
    end
  end

  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_idx  = 0;
  int   n_xfer   = 0;
  int   n_rden   = 0;
  int   n_stall  = 0;
  logic stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  bit   exp_rden  [7];
  bit   exp_valid [7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_mem[wr_ptr % FD] = w;
    wr_ptr++;
  endtask

  // One clock cycle: settle, run the per-cycle checks, advance to the next negedge.
  task automatic tick();
    logic was_flush;
    #1;
    chk("rd_en_while_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
    chk("level_range", 32'(buf_level <= BD), 32'd1);
    if (flush) chk("rd_en_in_flush", 32'(fifo_rd_en), 32'd0);
    if (stall_prev) begin
      chk("stall_valid_hold", 32'(m_if.valid), 32'd1);
      chk("stall_data_hold", 32'(m_if.data), 32'(prev_data));
    end
    if (m_if.valid && m_if.ready) begin
      chk("no_extra_word", 32'(exp_idx < wr_ptr), 32'd1);
      chk("stream_data", 32'(m_if.data), 32'(fifo_mem[exp_idx % FD]));
      exp_idx++;
      n_xfer++;
    end
    if (m_if.valid && !m_if.ready) n_stall++;
    stall_prev = m_if.valid && !m_if.ready && !flush;
    prev_data  = m_if.data;
    n_rden    += int'(fifo_rd_en);
    was_flush  = flush;
    @(posedge rd_clk);
    @(negedge rd_clk);
    if (was_flush) exp_idx = rd_ptr;
  endtask

  // Four words into an idle block with a ready sink: reads on cycles 0-3, data from cycle 2.
  task automatic latency_run(input logic [DW-1:0] first);
    for (int i = 0; i < 4; i++) push_word(first + DW'(i));
    m_if.ready  = 1'b1;
    flush       = 1'b0;
    force_empty = 1'b0;
    for (int c = 0; c < 7; c++) begin
      #1;
      chk("lat_rd_en", 32'(fifo_rd_en), 32'(exp_rden[c]));
      chk("lat_valid", 32'(m_if.valid), 32'(exp_valid[c]));
      if (c >= 2 && c <= 5) chk("lat_data", 32'(m_if.data), 32'(first + DW'(c - 2)));
      tick();
    end
  endtask

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    m_if.ready  = 1'b1;
    flush       = 1'b0;
    force_empty = 1'b0;
    while (exp_idx != wr_ptr && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_idx), 32'(wr_ptr));
  endtask

  initial begin
    int x0;
    int base;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] sw0;
    logic [31:0] ss0;
    int          st0;
`endif
    exp_rden  = '{1, 1, 1, 1, 0, 0, 0};
    exp_valid = '{0, 0, 1, 1, 1, 1, 0};
    rd_rst      = 1'b1;
    flush       = 1'b0;
    force_empty = 1'b0;
    m_if.ready  = 1'b0;
    repeat (2) @(negedge rd_clk);
    #1;
    chk("rst_valid", 32'(m_if.valid), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_level", 32'(buf_level), 32'd0);
    chk("rst_data", 32'(m_if.data), 32'd0);
    @(negedge rd_clk);
    rd_rst  = 1'b0;
    exp_idx = rd_ptr;

    // Latency and back-to-back throughput.
    latency_run(8'h11);

    // Backpressure: only BUF_DEPTH reads issued, head word held.
    for (int i = 0; i < 10; i++) push_word(8'($urandom));
    m_if.ready = 1'b0;
    n_rden = 0;
    repeat (6) tick();
    #1;
    chk("bp_reads", 32'(n_rden), 32'(BD));
    chk("bp_valid", 32'(m_if.valid), 32'd1);
    chk("bp_head", 32'(m_if.data), 32'(fifo_mem[exp_idx % FD]));
    chk("bp_level", 32'(buf_level), 32'(BD));
    m_if.ready = 1'b1;
    x0 = n_xfer;
    repeat (10) tick();
    chk("bp_rate", 32'(n_xfer - x0), 32'd10);
    chk("bp_done", 32'(exp_idx), 32'(wr_ptr));

    // Ready toggling over 16 words.
    for (int i = 0; i < 16; i++) push_word(8'($urandom));
    x0 = n_xfer;
`ifdef FIFO_RD_STREAM_STATS_EN
    sw0 = stat_words;
    ss0 = stat_stalls;
    st0 = n_stall;
`endif
    for (int n = 0; n < 80 && exp_idx != wr_ptr; n++) begin
      m_if.ready = (n % 2 == 0);
      tick();
    end
    chk("toggle_count", 32'(n_xfer - x0), 32'd16);
    chk("toggle_done", 32'(exp_idx), 32'(wr_ptr));
`ifdef FIFO_RD_STREAM_STATS_EN
    #1;
    chk("stat_words", stat_words - sw0, 32'd16);
    chk("stat_stalls", stat_stalls - ss0, 32'(n_stall - st0));
`endif
    drain(10, "toggle_drain");

    // Flush with one word buffered and one read in flight.
    for (int i = 0; i < 5; i++) push_word(8'($urandom));
    base = wr_ptr - 5;
    m_if.ready = 1'b0;
    repeat (2) tick();
    #1;
    chk("pre_flush_level", 32'(buf_level), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_valid", 32'(m_if.valid), 32'd0);
    chk("flush_level", 32'(buf_level), 32'd0);
    chk("flush_resume_idx", 32'(exp_idx), 32'(base + 2));
    drain(20, "flush_drain");

    // Empty flag toggling every cycle.
    for (int i = 0; i < 12; i++) push_word(8'($urandom));
    m_if.ready = 1'b1;
    for (int n = 0; n < 80 && exp_idx != wr_ptr; n++) begin
      force_empty = (n % 2 == 1);
      tick();
    end
    chk("toggle_empty_done", 32'(exp_idx), 32'(wr_ptr));
    drain(10, "toggle_empty_drain");

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 20; i++) push_word(8'($urandom));
    m_if.ready = 1'b1;
    repeat (5) tick();
    #3;
    rd_rst = 1'b1;
    #1;
    chk("arst_valid", 32'(m_if.valid), 32'd0);
    chk("arst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("arst_level", 32'(buf_level), 32'd0);
    @(negedge rd_clk);
    rd_rst     = 1'b0;
    stall_prev = 1'b0;
    exp_idx    = rd_ptr;
    latency_run(8'h40);

    // Random traffic with occasional flushes.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(2) == 0) push_word(8'($urandom));
      flush       = ($urandom_range(24) == 0);
      m_if.ready  = flush ? 1'b0 : 1'($urandom_range(1));
      force_empty = ($urandom_range(3) == 0);
      tick();
    end
    drain(300, "random_drain");
    #1;
    chk("final_valid", 32'(m_if.valid), 32'd0);
    chk("final_level", 32'(buf_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
